// File: rtl/ps2_pkg.sv
// PS/2 receiver shared types and constants.
// Bit-FSM states, Set-2 prefix bytes, bytes to ignore, Pause tail length.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } bit_st_e;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_REL   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam logic [7:0] PS2_BAT   = 8'hAA;
  localparam logic [7:0] PS2_ACK   = 8'hFA;
  localparam logic [7:0] PS2_RSND  = 8'hFE;
  localparam logic [7:0] PS2_ECHO  = 8'hEE;
  localparam logic [7:0] PS2_OVF0  = 8'h00;
  localparam logic [7:0] PS2_OVF1  = 8'hFF;

  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  function automatic logic is_discard(
    input logic [7:0] b
  );
    return (b == PS2_BAT)  || (b == PS2_ACK)  ||
           (b == PS2_RSND) || (b == PS2_ECHO) ||
           (b == PS2_OVF0) || (b == PS2_OVF1);
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// 2-FF synchronizer plus FILTER_LEN-sample stability filter.
// Ports: clk_i, reset_i, raw_i -> level_o (filtered), fall_o (1-cycle 1->0).
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples that disagree with the level;
  // the FILTER_LEN-th disagreeing sample flips the level.
  always_comb begin
    lvl_d  = lvl_q;
    fall_d = 1'b0;
    cnt_d  = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        lvl_d  = s2_q;
        fall_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      lvl_q  <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level_o = lvl_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 Set-2 receiver: bit framing, E0/F0/E1 prefix resolution.
// Ports: clk_sys, reset, ps2_clk, ps2_data -> ps2_key[10:0], frame_err.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 12000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          clk_lvl, fall;
  logic          d1_q, d2_q;
  bit_st_e       st_q, st_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d;
  logic          rel_q, rel_d;
  logic [2:0]    skip_q, skip_d;
  logic [10:0]   key_q, key_d;
  logic          err, byte_done;

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filt (
    .clk_i  (clk_sys),
    .reset_i(reset),
    .raw_i  (ps2_clk),
    .level_o(clk_lvl),
    .fall_o (fall)
  );

  always_comb begin
    st_d      = st_q;
    bcnt_d    = bcnt_q;
    sh_d      = sh_q;
    par_d     = par_q;
    err       = 1'b0;
    byte_done = 1'b0;

    // tmo_q = cycles since the last fall while a frame is open
    if (fall)                tmo_d = TW'(1);
    else if (st_q == ST_IDLE) tmo_d = '0;
    else                     tmo_d = tmo_q + 1'b1;

    if (st_q != ST_IDLE && tmo_q == TW'(TIMEOUT)) begin
      err    = 1'b1;
      st_d   = ST_IDLE;
      bcnt_d = '0;
    end else if (fall) begin
      unique case (st_q)
        ST_IDLE: begin
          if (d2_q) begin
            err = 1'b1;
          end else begin
            st_d   = ST_DATA;
            bcnt_d = '0;
          end
        end
        ST_DATA: begin
          sh_d   = {d2_q, sh_q[7:1]};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 3'd7) st_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d = d2_q;
          st_d  = ST_STOP;
        end
        ST_STOP: begin
          st_d = ST_IDLE;
          if (d2_q && (^{sh_q, par_q})) byte_done = 1'b1;
          else                           err       = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    ext_d  = ext_q;
    rel_d  = rel_q;
    skip_d = skip_q;
    key_d  = key_q;
    if (err) begin
      ext_d  = 1'b0;
      rel_d  = 1'b0;
      skip_d = '0;
    end else if (byte_done) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 1'b1;
      end else begin
        unique case (1'b1)
          (sh_q == PS2_EXT):   ext_d  = 1'b1;
          (sh_q == PS2_REL):   rel_d  = 1'b1;
          (sh_q == PS2_PAUSE): skip_d = PAUSE_TAIL;
          is_discard(sh_q):    ;
          default: begin
            key_d = {~key_q[10], ~rel_q, ext_q, sh_q};
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      d1_q   <= 1'b1;
      d2_q   <= 1'b1;
      st_q   <= ST_IDLE;
      bcnt_q <= '0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      tmo_q  <= '0;
      ext_q  <= 1'b0;
      rel_q  <= 1'b0;
      skip_q <= '0;
      key_q  <= '0;
    end else begin
      d1_q   <= ps2_data;
      d2_q   <= d1_q;
      st_q   <= st_d;
      bcnt_q <= bcnt_d;
      sh_q   <= sh_d;
      par_q  <= par_d;
      tmo_q  <= tmo_d;
      ext_q  <= ext_d;
      rel_q  <= rel_d;
      skip_q <= skip_d;
      key_q  <= key_d;
    end
  end

  // The filtered level itself is not needed beyond its fall strobe.
  logic unused_lvl;
  assign unused_lvl = clk_lvl;

  assign ps2_key   = key_q;
  assign frame_err = err & ~reset;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx.
// Frame table plus timeout, bad-start and mid-frame reset sequences.
module tb_ps2_scancode_rx;

  localparam int FL   = 4;
  localparam int TO   = 200;
  localparam int HALF = 20;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  int total   = 0;
  int bad     = 0;
  int err_cnt = 0;

  ps2_scancode_rx #(
    .FILTER_LEN(FL),
    .TIMEOUT   (TO)
  ) u_dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  // counts high cycles, so a 2-cycle pulse shows as 2
  always @(negedge clk_sys)
    if (frame_err) err_cnt++;

  typedef struct {
    logic [7:0]  b;
    logic        badp;
    logic        glit;
    logic [10:0] key;
    int          errs;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] b, input logic badp,
                     input logic glit, input logic [10:0] key,
                     input int errs);
    vec_t r;
    r.b = b; r.badp = badp; r.glit = glit;
    r.key = key; r.errs = errs;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic ps2_bit(input logic b, input logic g);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
    if (g) begin
      tick(10);
      ps2_clk = 1'b0;
      tick(FL - 1);
      ps2_clk = 1'b1;
      tick(HALF - 10 - (FL - 1));
    end else begin
      tick(HALF);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic badp,
                      input logic g);
    ps2_bit(1'b0, g);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], g);
    ps2_bit((~^b) ^ badp, g);
    ps2_bit(1'b1, g);
    ps2_data = 1'b1;
    tick(20);
  endtask

  task automatic run(input int lo, input int hi);
    int e0;
    for (int i = lo; i <= hi; i++) begin
      e0 = err_cnt;
      send(tbl[i].b, tbl[i].badp, tbl[i].glit);
      chk($sformatf("key[%0d]", i), ps2_key, tbl[i].key);
      chk($sformatf("err[%0d]", i), err_cnt - e0, tbl[i].errs);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    int e0;
    int first;

    add(8'h29, 0, 0, 11'h629, 0);
    add(8'hF0, 0, 0, 11'h629, 0);
    add(8'h29, 0, 0, 11'h029, 0);
    add(8'hE0, 0, 0, 11'h029, 0);
    add(8'h75, 0, 0, 11'h775, 0);
    add(8'hE0, 0, 0, 11'h775, 0);
    add(8'hF0, 0, 0, 11'h775, 0);
    add(8'h75, 0, 0, 11'h175, 0);
    add(8'hF0, 0, 0, 11'h175, 0);
    add(8'h14, 1, 0, 11'h175, 1);
    add(8'h14, 0, 0, 11'h614, 0);
    add(8'h1C, 0, 0, 11'h21C, 0);
    add(8'h5A, 0, 1, 11'h65A, 0);
    add(8'hE1, 0, 0, 11'h65A, 0);
    add(8'h14, 0, 0, 11'h65A, 0);
    add(8'h77, 0, 0, 11'h65A, 0);
    add(8'hE1, 0, 0, 11'h65A, 0);
    add(8'hF0, 0, 0, 11'h65A, 0);
    add(8'h14, 0, 0, 11'h65A, 0);
    add(8'hF0, 0, 0, 11'h65A, 0);
    add(8'h77, 0, 0, 11'h65A, 0);
    add(8'h16, 0, 0, 11'h216, 0);
    add(8'hE0, 0, 0, 11'h216, 0);
    add(8'hAA, 0, 0, 11'h216, 0);
    add(8'h6B, 0, 0, 11'h76B, 0);
    add(8'h2E, 0, 0, 11'h62E, 0);

    tick(3);
    chk("rst_key", ps2_key, 11'h000);
    chk("rst_err", frame_err, 1'b0);
    reset = 1'b0;
    tick(5);

    run(0, 10);

    // timeout: start + 3 data bits, then a 5th fall and silence
    e0 = err_cnt;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    tick(HALF);
    ps2_clk = 1'b0;
    first = 0;
    for (int k = 1; k <= 2 + FL + TO + 20; k++) begin
      @(posedge clk_sys);
      #1;
      if (frame_err && first == 0) first = k;
      if (k == HALF) ps2_clk = 1'b1;
    end
    chk("tmo_lat", first, 2 + FL + TO);
    chk("tmo_cnt", err_cnt - e0, 1);
    chk("tmo_key", ps2_key, 11'h614);
    tick(20);

    run(11, 24);

    // bad start bit
    e0 = err_cnt;
    ps2_data = 1'b1;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
    tick(HALF);
    chk("start_err", err_cnt - e0, 1);
    chk("start_key", ps2_key, 11'h76B);

    // reset between data bit 3 and 4
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0], 1'b0);
    e0 = err_cnt;
    reset = 1'b1;
    tick(1);
    chk("mrst_key", ps2_key, 11'h000);
    chk("mrst_err", frame_err, 1'b0);
    reset = 1'b0;
    ps2_data = 1'b1;
    tick(TO + 50);
    chk("mrst_cnt", err_cnt - e0, 0);

    run(25, 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

Receives the raw PS/2 keyboard serial stream (clock/data lines) and decodes Set-2 scancode frames. It resolves the E0 (extended) and F0 (break) prefixes and publishes each key event in the 11-bit toggle format that the core's keyboard handler consumes: bit 10 toggles per event, bit 9 is pressed, bits 8:0 are the code. It sits between the board PS/2 pins and the per-core key-mapping logic, in place of the HPS-supplied key word.

## Interface
Parameters:
- FILTER_LEN, 8: number of consecutive identical clk_sys samples required before the filtered PS/2 clock changes level.
- TIMEOUT, 12000: clk_sys cycles without a filtered falling edge after which an in-progress frame is aborted (about 1 ms at 12 MHz).

Ports:
- clk_sys, in, 1: system clock. All logic runs on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- ps2_clk, in, 1: raw PS/2 clock line, asynchronous to clk_sys.
- ps2_data, in, 1: raw PS/2 data line, asynchronous to clk_sys.
- ps2_key, out, 11: {toggle, pressed, extended, code[7:0]}.
- frame_err, out, 1: one-cycle pulse on a parity error, stop error, bad start bit, or timeout.

## Operation
- Line conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - Filtered clock starts at 1. It takes the synchronized value only after that value has differed from the current filtered value for FILTER_LEN consecutive cycles.
  - A 1→0 transition of the filtered clock produces a one-cycle `fall` strobe. Data is sampled on `fall`.
- Bit FSM (states IDLE, DATA, PARITY, STOP):
  - IDLE, on fall: data=0 → DATA with bit count 0. Data=1 → pulse frame_err and stay in IDLE.
  - DATA: shift data in LSB-first, 8 bits, then go to PARITY.
  - PARITY: capture the parity bit. Odd parity over data+parity is required.
  - STOP: stop bit must be 1. If parity is good and stop is 1, issue byte_done with the byte. Otherwise pulse frame_err and discard the byte. In either case return to IDLE.
  - Timeout counter resets on every fall. In any state other than IDLE, reaching TIMEOUT → pulse frame_err, return to IDLE, discard partial bits.
- Prefix decoder, acting on each byte_done:
  - 0xE0: set ext.
  - 0xF0: set rel.
  - 0xE1: load skip=7. The next 7 bytes are discarded (Pause sequence); no event is produced.
  - 0xAA, 0xFA, 0xFE, 0xEE, 0x00, 0xFF: discarded, ext and rel unchanged.
  - Any other byte b: ps2_key <= {~ps2_key[10], ~rel, ext, b}, then clear ext and rel.
- Any frame_err clears ext, rel and skip, so no prefix survives a corrupted frame.
- Reset:
  - ps2_key=0, frame_err=0.
  - FSM in IDLE, bit count 0, ext=rel=0, skip=0.
  - Filtered clock=1, filter and timeout counters at 0.
  - Reset asserted mid-frame discards the partial frame with no frame_err.

## Timing
- fall asserts 2 (sync) + FILTER_LEN cycles after the raw ps2_clk falling edge, assuming clean input.
- byte_done and frame_err are combinational on the fall that samples the stop bit, cycle N.
- ps2_key is registered at N+1.
- ps2_key changes at most once per frame, and only via toggle inversion. Downstream detects events by comparing bit 10.
- frame_err is exactly one cycle wide. It never coincides with a ps2_key update.
- Glitches shorter than FILTER_LEN cycles on ps2_clk produce no fall.
- Timeout boundary: fall arriving on the cycle the counter reaches TIMEOUT-1 is accepted. At counter == TIMEOUT the frame is aborted.

## Structure
- Shared package ps2_pkg:
  - bit-FSM state enum.
  - prefix constants: PS2_EXT=8'hE0, PS2_REL=8'hF0, PS2_PAUSE=8'hE1.
  - discard-set constants.
  - PAUSE_TAIL=7.
- Sub-module ps2_sync_filter (2-FF sync plus FILTER_LEN stability filter, outputs level and fall strobe). Instantiate it for ps2_clk. ps2_data uses only the synchronizer stage.
- Bit FSM and prefix decoder stay in this module.

## Test plan
- From reset, send frame 0x29 → ps2_key=11'h629, no frame_err. Then send F0,29 → ps2_key=11'h029.
- Send E0,75 → ps2_key=11'h775. Then send E0,F0,75 → ps2_key=11'h175.
- Send F0, then 0x14 with wrong parity → one-cycle frame_err, ps2_key unchanged. Then send good 0x14 → make event: toggle flipped, bit9=1, code 0x014, proving rel was cleared.
- Send start bit plus 4 data bits and stop clocking → frame_err exactly TIMEOUT cycles after the last fall. Next full frame 0x1C decodes normally.
- Inject ps2_clk low pulses of FILTER_LEN-1 cycles mid-frame → no extra bits, byte decodes correctly. Send E1,14,77,E1,F0,14,F0,77 → no ps2_key change. Following 0x16 → make event.
- Assert reset between data bit 3 and 4 → all outputs 0 on the next cycle, no frame_err. Next clean frame 0x2E → ps2_key=11'h62E.
